// File: rtl/iob_axil2ibex_mem_pkg.sv
// rtl/iob_axil2ibex_mem_pkg.sv - shared types and constants for the AXI4-Lite to Ibex data-port bridge
package iob_axil2ibex_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    B_RSP,
    RD_REQ,
    RD_WAIT,
    R_RSP
  } state_t;

endpackage

// File: rtl/iob_axil2ibex_mem_timeout.sv
// rtl/iob_axil2ibex_mem_timeout.sv - memory watchdog counter and drain flag for stray late responses
module iob_axil2ibex_mem_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_active,
  input  logic i_in_wait,
  input  logic i_mem_rvalid,
  output logic o_timeout,
  output logic o_drain
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_drain;

  assign o_timeout = i_active && (r_cnt == CNT_W'(TIMEOUT_CYC));
  assign o_drain   = r_drain;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else begin
      if (!i_active) begin
        r_cnt <= '0;
      end else if (!o_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A response abandoned in WAIT may still arrive; swallow exactly one.
      if (o_timeout && i_in_wait && !i_mem_rvalid) begin
        r_drain <= 1'b1;
      end else if (r_drain && i_mem_rvalid) begin
        r_drain <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iob_axil2ibex_mem.sv
// rtl/iob_axil2ibex_mem.sv - AXI4-Lite subordinate driving a single-word Ibex req/gnt/rvalid data port
// Optional memory watchdog enabled by IOB_AXIL2IBEX_MEM_TIMEOUT_EN.
module iob_axil2ibex_mem
  import iob_axil2ibex_mem_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int MEM_ADDR_W  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [AXI_ADDR_W-1:0] awaddr_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [AXI_ADDR_W-1:0] araddr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_err_i
);

  state_t                r_state, w_state_nxt;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata, r_rdata;
  logic [3:0]            r_be;
  logic                  r_we, r_last_rd;
  logic [1:0]            r_bresp, r_rresp;

  logic w_aw_oor, w_ar_oor, w_sel_wr, w_sel_rd, w_timeout, w_drain;
  logic [MEM_ADDR_W-1:0] w_aw_maddr, w_ar_maddr;

  if (MEM_ADDR_W < AXI_ADDR_W) begin : g_dec
    assign w_aw_oor = |awaddr_i[AXI_ADDR_W-1:MEM_ADDR_W];
    assign w_ar_oor = |araddr_i[AXI_ADDR_W-1:MEM_ADDR_W];
  end else begin : g_nodec
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
  end

  assign w_aw_maddr = awaddr_i[MEM_ADDR_W-1:0] & ~MEM_ADDR_W'(3);
  assign w_ar_maddr = araddr_i[MEM_ADDR_W-1:0] & ~MEM_ADDR_W'(3);

  // Round-robin: on a tie the type not served last wins.
  assign w_sel_wr = awvalid_i && wvalid_i && (!arvalid_i || r_last_rd);
  assign w_sel_rd = arvalid_i && !w_sel_wr;

`ifdef IOB_AXIL2IBEX_MEM_TIMEOUT_EN
  logic w_active, w_in_wait;
  assign w_in_wait = (r_state == WR_WAIT) || (r_state == RD_WAIT);
  assign w_active  = w_in_wait || (r_state == WR_REQ) || (r_state == RD_REQ);

  iob_axil2ibex_mem_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_active    (w_active),
    .i_in_wait   (w_in_wait),
    .i_mem_rvalid(mem_rvalid_i),
    .o_timeout   (w_timeout),
    .o_drain     (w_drain)
  );
`else
  assign w_timeout = 1'b0;
  assign w_drain   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    awready_o   = 1'b0;
    wready_o    = 1'b0;
    arready_o   = 1'b0;
    bvalid_o    = 1'b0;
    rvalid_o    = 1'b0;
    mem_req_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_drain) begin
          if (w_sel_wr) begin
            awready_o   = 1'b1;
            wready_o    = 1'b1;
            w_state_nxt = w_aw_oor ? B_RSP : WR_REQ;
          end else if (w_sel_rd) begin
            arready_o   = 1'b1;
            w_state_nxt = w_ar_oor ? R_RSP : RD_REQ;
          end
        end
      end
      WR_REQ: begin
        mem_req_o = !w_timeout;
        if (w_timeout)      w_state_nxt = B_RSP;
        else if (mem_gnt_i) w_state_nxt = WR_WAIT;
      end
      WR_WAIT: if (mem_rvalid_i || w_timeout) w_state_nxt = B_RSP;
      B_RSP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_nxt = IDLE;
      end
      RD_REQ: begin
        mem_req_o = !w_timeout;
        if (w_timeout)      w_state_nxt = R_RSP;
        else if (mem_gnt_i) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: if (mem_rvalid_i || w_timeout) w_state_nxt = R_RSP;
      R_RSP: begin
        rvalid_o = 1'b1;
        if (rready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_last_rd <= 1'b1;
      r_bresp   <= OKAY;
      r_rresp   <= OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (awready_o) begin
            r_addr    <= w_aw_maddr;
            r_wdata   <= wdata_i;
            r_be      <= wstrb_i;
            r_we      <= 1'b1;
            r_last_rd <= 1'b0;
            r_bresp   <= w_aw_oor ? DECERR : OKAY;
          end else if (arready_o) begin
            r_addr    <= w_ar_maddr;
            r_be      <= 4'hF;
            r_we      <= 1'b0;
            r_last_rd <= 1'b1;
            r_rresp   <= w_ar_oor ? DECERR : OKAY;
            r_rdata   <= '0;
          end
        end
        WR_REQ: if (w_timeout) r_bresp <= SLVERR;
        WR_WAIT: begin
          if (mem_rvalid_i)   r_bresp <= mem_err_i ? SLVERR : OKAY;
          else if (w_timeout) r_bresp <= SLVERR;
        end
        RD_REQ: if (w_timeout) r_rresp <= SLVERR;
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            r_rresp <= mem_err_i ? SLVERR : OKAY;
            r_rdata <= mem_rdata_i;
          end else if (w_timeout) begin
            r_rresp <= SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign bresp_o     = r_bresp;
  assign rresp_o     = r_rresp;
  assign rdata_o     = r_rdata;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: doc/iob_axil2ibex_mem.md
# iob_axil2ibex_mem

AXI4-Lite subordinate that converts incoming AXI read and write transactions into single-word accesses on an Ibex-style data memory port (req/gnt/rvalid). It sits in front of Ibex-protocol memories and peripherals so that AXI managers, including our Ibex-to-AXI manager bridge, can reach them. One transaction is in flight at a time. Data width is fixed at 32 bits.

## Interface
- AXI_ADDR_W, 32, AXI byte-address width.
- MEM_ADDR_W, 16, memory byte-address width; must be at most AXI_ADDR_W.
- TIMEOUT_CYC, 255, memory watchdog limit in cycles; used only with the timeout macro.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- awvalid_i / awready_o  in / out  1  AW handshake.
- awaddr_i  in  AXI_ADDR_W  write byte address.
- wvalid_i / wready_o  in / out  1  W handshake.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte strobes.
- bvalid_o / bready_i  out / in  1  B handshake.
- bresp_o  out  2  write response.
- arvalid_i / arready_o  in / out  1  AR handshake.
- araddr_i  in  AXI_ADDR_W  read byte address.
- rvalid_o / rready_i  out / in  1  R handshake.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  MEM_ADDR_W  word-aligned byte address.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  request granted.
- mem_rvalid_i  in  1  response valid.
- mem_rdata_i  in  32  read data.
- mem_err_i  in  1  error, qualified by mem_rvalid_i.

## Operation
- FSM states: IDLE, WR_REQ, WR_WAIT, B_RSP, RD_REQ, RD_WAIT, R_RSP.
- Write accept in IDLE:
  - Requires awvalid_i and wvalid_i high together.
  - awready_o and wready_o rise in that same cycle; both channels are accepted jointly.
  - Address, data and strobes are registered.
- Read accept in IDLE: arready_o is high when arvalid_i is high and the write pair is not selected.
- Arbitration when both requests are pending: round-robin. A last-served bit selects the other type. The bit resets to "read last", so the first tie goes to the write.
- Address decode: any awaddr/araddr bit at position MEM_ADDR_W or above set means no memory access. The FSM goes directly to B_RSP or R_RSP with DECERR; rdata_o is 0.
- mem_addr_o is the address with bits [1:0] forced to 0. mem_be_o equals wstrb_i on writes and 4'hF on reads.
- WR_REQ and RD_REQ:
  - mem_req_o is held high with stable outputs until mem_gnt_i.
  - On grant, the FSM moves to WR_WAIT or RD_WAIT.
- WR_WAIT and RD_WAIT:
  - On mem_rvalid_i, the response is registered: OKAY, or SLVERR if mem_err_i is set.
  - rdata_o captures mem_rdata_i on reads.
- B_RSP and R_RSP: bvalid_o or rvalid_o is held with stable payload until bready_i or rready_i, then the FSM returns to IDLE.
- mem_rvalid_i outside the WAIT states is ignored.

## Timing
- Reset values:
  - FSM in IDLE.
  - bvalid_o, rvalid_o and mem_req_o are 0.
  - bresp_o, rresp_o, rdata_o, mem_* data/address outputs and mem_we_o are 0.
  - Ready outputs follow the IDLE rule in the first cycle after reset.
- Minimum write latency, with handshake at cycle T:
  - mem_req_o at T+1.
  - mem_gnt_i at T+1.
  - mem_rvalid_i at T+2.
  - bvalid_o at T+3.
- Reads have the same latency.
- A DECERR response is valid at T+1.
- The next accept happens no earlier than the cycle after the B or R handshake.
- Reset asserted mid-operation returns the FSM to IDLE in the next cycle. Pending memory responses are dropped.

## Configuration
- IOB_AXIL2IBEX_MEM_TIMEOUT_EN defined:
  - A counter runs during the REQ and WAIT states.
  - When it reaches TIMEOUT_CYC, mem_req_o drops and the FSM enters the response state with SLVERR.
  - After a WAIT timeout, a drain flag is set. The next mem_rvalid_i is discarded and clears the flag. New accepts are blocked while the flag is set.
- Macro undefined: no counter and no drain flag; the FSM waits indefinitely. TIMEOUT_CYC is unused.

## Structure
- Package iob_axil2ibex_mem_pkg holds:
  - The FSM state enum.
  - Response constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - DATA_W=32.
- Sub-module iob_axil2ibex_mem_timeout holds the watchdog counter and drain flag. It is instantiated only under the macro.

## Test plan
- Write to 0x10 with data 0xDEADBEEF and strb 4'b0011; grant in the same cycle, rvalid one cycle later → mem_be_o=4'b0011 and mem_addr_o=0x10; bvalid_o three cycles after the handshake with bresp_o=OKAY.
- Read from 0x14; memory returns 0x12345678 with mem_err_i=1 → rdata_o=0x12345678 and rresp_o=SLVERR. Hold rready_i low for 4 cycles → rvalid_o and rdata_o stay stable.
- Write and read presented in the same cycle, twice in a row → the write is served first, then the read, then the write again.
- Read from address 1<<MEM_ADDR_W → mem_req_o is never asserted; rresp_o=DECERR and rdata_o=0.
- Withhold mem_gnt_i for 10 cycles → mem_req_o and mem_addr_o stay stable. Assert rst_i in WR_WAIT → outputs return to reset values and a later mem_rvalid_i is ignored.
- With TIMEOUT_CYC=8 and the macro defined: never grant → SLVERR on B. Separately, grant but never rvalid → SLVERR on B; the next stray mem_rvalid_i is discarded before a new write is accepted.
